// File: rtl/icache_victim_ctrl_if.sv
// rtl/icache_victim_ctrl_if.sv - miss/hit/refill signal bundle for the icache victim controller
interface icache_victim_ctrl_if #(
  parameter int N_WAY = 4,
  parameter int WAY_W = 2,
  parameter int SET_W = 6
);
  logic             miss_i;
  logic [SET_W-1:0] miss_set_i;
  logic [N_WAY-1:0] valid_ways_i;
  logic             hit_i;
  logic [SET_W-1:0] hit_set_i;
  logic [WAY_W-1:0] hit_way_i;
  logic             flush_i;
  logic             refill_req_o;
  logic [WAY_W-1:0] refill_way_o;
  logic [SET_W-1:0] refill_set_o;
  logic             refill_ack_i;
  logic             busy_o;

  modport master (
    output miss_i, miss_set_i, valid_ways_i, hit_i, hit_set_i, hit_way_i,
    output flush_i, refill_ack_i,
    input  refill_req_o, refill_way_o, refill_set_o, busy_o
  );

  modport slave (
    input  miss_i, miss_set_i, valid_ways_i, hit_i, hit_set_i, hit_way_i,
    input  flush_i, refill_ack_i,
    output refill_req_o, refill_way_o, refill_set_o, busy_o
  );
endinterface

// File: rtl/icache_victim_ctrl.sv
// rtl/icache_victim_ctrl.sv - victim way selection, refill request handshake and per-set tree PLRU
module icache_victim_ctrl #(
  parameter int N_WAY = 4,
  parameter int WAY_W = 2,
  parameter int SET_W = 6
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  icache_victim_ctrl_if.slave  bus
);
  localparam int N_SET  = 1 << SET_W;
  localparam int N_NODE = N_WAY - 1;

  typedef logic [N_NODE-1:0] tree_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_REFILL} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] set_q;
  logic [N_WAY-1:0] valid_q;
  logic [WAY_W-1:0] way_q;
  logic [SET_W-1:0] rset_q;
  logic             flush_pend_q;
  tree_t            plru_q [N_SET];

  logic             busy;
  logic             accept;
  logic             clear;
  logic             refill_touch;
  logic             hit_touch;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] lowest_inv;
  logic             found_inv;
  tree_t            hit_tree;
  tree_t            refill_tree;

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); bit value picks the LRU side.
  function automatic logic [WAY_W-1:0] plru_victim(input tree_t t);
    logic [N_WAY-1:0] tp;
    logic [WAY_W-1:0] w;
    logic [WAY_W-1:0] idx;
    tp = {1'b0, t};
    w  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      idx = WAY_W'((1 << l) - 1) + w;
      w   = (w << 1) | WAY_W'(tp[idx]);
    end
    return w;
  endfunction

  function automatic tree_t plru_touch(input tree_t t, input logic [WAY_W-1:0] w);
    logic [N_WAY-1:0] tp;
    logic [WAY_W-1:0] idx;
    logic [WAY_W-1:0] pre;
    logic [WAY_W-1:0] bitv;
    tp = {1'b0, t};
    for (int l = 0; l < WAY_W; l++) begin
      pre     = w >> (WAY_W - l);
      bitv    = w >> (WAY_W - 1 - l);
      idx     = WAY_W'((1 << l) - 1) + pre;
      tp[idx] = ~bitv[0];
    end
    return tp[N_NODE-1:0];
  endfunction

  assign busy         = (state_q != ST_IDLE) | flush_pend_q;
  assign accept       = (state_q == ST_IDLE) & bus.miss_i & ~busy & ~bus.flush_i;
  assign clear        = (state_q == ST_IDLE) & (bus.flush_i | flush_pend_q);
  assign refill_touch = (state_q == ST_REFILL) & bus.refill_ack_i;
  // On a same-set collision the refill touch wins and the hit touch is dropped.
  assign hit_touch    = bus.hit_i & ~(refill_touch & (bus.hit_set_i == set_q));
  assign hit_tree     = plru_touch(plru_q[bus.hit_set_i], bus.hit_way_i);
  assign refill_tree  = plru_touch(plru_q[set_q], way_q);

  always_comb begin
    lowest_inv = '0;
    found_inv  = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!valid_q[i] && !found_inv) begin
        lowest_inv = WAY_W'(i);
        found_inv  = 1'b1;
      end
    end
  end

  assign victim = found_inv ? lowest_inv : plru_victim(plru_q[set_q]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SELECT;
      ST_SELECT: state_d = ST_REFILL;
      ST_REFILL: if (bus.refill_ack_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      set_q        <= '0;
      valid_q      <= '0;
      way_q        <= '0;
      rset_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        set_q   <= bus.miss_set_i;
        valid_q <= bus.valid_ways_i;
      end
      if (state_q == ST_SELECT) begin
        way_q  <= victim;
        rset_q <= set_q;
      end
      if (clear) begin
        flush_pend_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && bus.flush_i) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
    end else if (clear) begin
      for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
    end else begin
      if (hit_touch)    plru_q[bus.hit_set_i] <= hit_tree;
      if (refill_touch) plru_q[set_q]         <= refill_tree;
    end
  end

  assign bus.refill_req_o = (state_q == ST_REFILL);
  assign bus.refill_way_o = way_q;
  assign bus.refill_set_o = rset_q;
  assign bus.busy_o       = busy;
endmodule

// File: tb/tb_icache_victim_ctrl.sv
// tb/tb_icache_victim_ctrl.sv - table-driven and scoreboard bench for icache_victim_ctrl
module tb_icache_victim_ctrl;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [5:0] set;
    logic [1:0] way;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit         do_hit;
    logic [5:0] hset;
    logic [1:0] hway;
    logic [5:0] mset;
    logic [3:0] valid;
    logic [1:0] exp_way;
    int         dly;
  } vec_t;
  vec_t vecs[12];

  icache_victim_ctrl_if #(.N_WAY(4), .WAY_W(2), .SET_W(6)) ifc();

  icache_victim_ctrl #(.N_WAY(4), .WAY_W(2), .SET_W(6)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic req_prev;
  initial req_prev = 1'b0;
  always @(negedge clk) begin
    if (rstn && ifc.refill_req_o && !req_prev) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_req", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_way", 32'(ifc.refill_way_o), 32'(e.way));
        check("sb_set", 32'(ifc.refill_set_o), 32'(e.set));
      end
    end
    req_prev = ifc.refill_req_o;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (ifc.busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ifc.busy_o) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_miss(input logic [5:0] s, input logic [3:0] v, input logic [1:0] exp_w,
                         input int dly, input bit toggle, input bit flush_mid,
                         input bit ack_hit, input logic [5:0] hs, input logic [1:0] hw);
    sb_t e;
    wait_idle();
    ifc.miss_i       = 1'b1;
    ifc.miss_set_i   = s;
    ifc.valid_ways_i = v;
    e.set = s;
    e.way = exp_w;
    sb.push_back(e);
    @(negedge clk);
    ifc.miss_i = 1'b0;
    check("lat_req_n1", 32'(ifc.refill_req_o), 32'd0);
    check("lat_busy_n1", 32'(ifc.busy_o), 32'd1);
    @(negedge clk);
    check("lat_req_n2", 32'(ifc.refill_req_o), 32'd1);
    for (int i = 0; i < dly; i++) begin
      if (toggle) begin
        ifc.miss_i       = ~ifc.miss_i;
        ifc.miss_set_i   = 6'(i + 40);
        ifc.valid_ways_i = 4'b0000;
      end
      ifc.flush_i = flush_mid && (i == 0);
      @(negedge clk);
      check("hold_req", 32'(ifc.refill_req_o), 32'd1);
      check("hold_way", 32'(ifc.refill_way_o), 32'(exp_w));
      check("hold_set", 32'(ifc.refill_set_o), 32'(s));
      check("hold_busy", 32'(ifc.busy_o), 32'd1);
    end
    ifc.miss_i       = 1'b0;
    ifc.flush_i      = 1'b0;
    ifc.refill_ack_i = 1'b1;
    ifc.hit_i        = ack_hit;
    ifc.hit_set_i    = hs;
    ifc.hit_way_i    = hw;
    @(negedge clk);
    ifc.refill_ack_i = 1'b0;
    ifc.hit_i        = 1'b0;
    check("req_drop", 32'(ifc.refill_req_o), 32'd0);
    check("busy_after_ack", 32'(ifc.busy_o), 32'(flush_mid));
    if (flush_mid) begin
      @(negedge clk);
      check("flush_busy_clear", 32'(ifc.busy_o), 32'd0);
    end
  endtask

  task automatic simple_miss(input logic [5:0] s, input logic [3:0] v, input logic [1:0] exp_w, input int dly);
    do_miss(s, v, exp_w, dly, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // {do_hit, hit_set, hit_way, miss_set, valid, expected victim, ack delay}
    vecs[0]  = '{0, 6'd0, 2'd0, 6'd5, 4'b1011, 2'd2, 0};
    vecs[1]  = '{0, 6'd0, 2'd0, 6'd3, 4'hF,    2'd0, 1};
    vecs[2]  = '{0, 6'd0, 2'd0, 6'd3, 4'hF,    2'd2, 2};
    vecs[3]  = '{0, 6'd0, 2'd0, 6'd3, 4'hF,    2'd1, 0};
    vecs[4]  = '{0, 6'd0, 2'd0, 6'd3, 4'hF,    2'd3, 3};
    vecs[5]  = '{1, 6'd3, 2'd0, 6'd3, 4'hF,    2'd2, 1};
    vecs[6]  = '{0, 6'd0, 2'd0, 6'd4, 4'hF,    2'd0, 0};
    vecs[7]  = '{0, 6'd0, 2'd0, 6'd7, 4'b0000, 2'd0, 2};
    vecs[8]  = '{0, 6'd0, 2'd0, 6'd7, 4'b0111, 2'd3, 1};
    vecs[9]  = '{0, 6'd0, 2'd0, 6'd7, 4'hF,    2'd1, 0};
    vecs[10] = '{1, 6'd7, 2'd2, 6'd7, 4'hF,    2'd0, 2};
    vecs[11] = '{0, 6'd0, 2'd0, 6'd5, 4'hF,    2'd0, 1};

    rstn             = 1'b0;
    ifc.miss_i       = 1'b0;
    ifc.miss_set_i   = '0;
    ifc.valid_ways_i = '0;
    ifc.hit_i        = 1'b0;
    ifc.hit_set_i    = '0;
    ifc.hit_way_i    = '0;
    ifc.flush_i      = 1'b0;
    ifc.refill_ack_i = 1'b0;
    #1;
    check("rst_req", 32'(ifc.refill_req_o), 32'd0);
    check("rst_way", 32'(ifc.refill_way_o), 32'd0);
    check("rst_set", 32'(ifc.refill_set_o), 32'd0);
    check("rst_busy", 32'(ifc.busy_o), 32'd0);
    apply_reset();

    for (int k = 0; k < 12; k++) begin
      wait_idle();
      if (vecs[k].do_hit) begin
        ifc.hit_i     = 1'b1;
        ifc.hit_set_i = vecs[k].hset;
        ifc.hit_way_i = vecs[k].hway;
        @(negedge clk);
        ifc.hit_i = 1'b0;
      end
      simple_miss(vecs[k].mset, vecs[k].valid, vecs[k].exp_way, vecs[k].dly);
    end

    // Long ack delay with miss_i toggling throughout.
    do_miss(6'd9, 4'hF, 2'd0, 10, 1'b1, 1'b0, 1'b0, 6'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_req", 32'(ifc.refill_req_o), 32'd0);
    end

    // Flush during REFILL defers the clear to the first IDLE cycle.
    do_miss(6'd10, 4'hF, 2'd0, 2, 1'b0, 1'b1, 1'b0, 6'd0, 2'd0);
    simple_miss(6'd10, 4'hF, 2'd0, 0);
    // Flush in IDLE blocks a same-cycle miss and clears set 10.
    ifc.flush_i      = 1'b1;
    ifc.miss_i       = 1'b1;
    ifc.miss_set_i   = 6'd10;
    ifc.valid_ways_i = 4'hF;
    @(negedge clk);
    ifc.flush_i = 1'b0;
    ifc.miss_i  = 1'b0;
    check("idle_flush_no_accept", 32'(ifc.busy_o), 32'd0);
    @(negedge clk);
    check("idle_flush_no_req", 32'(ifc.refill_req_o), 32'd0);
    simple_miss(6'd10, 4'hF, 2'd0, 1);

    // Same-cycle refill touch and hit touch.
    apply_reset();
    do_miss(6'd3, 4'hF, 2'd0, 2, 1'b0, 1'b0, 1'b1, 6'd3, 2'd2);
    do_miss(6'd3, 4'hF, 2'd2, 1, 1'b0, 1'b0, 1'b1, 6'd6, 2'd0);
    simple_miss(6'd6, 4'hF, 2'd2, 0);
    simple_miss(6'd3, 4'hF, 2'd1, 0);

    // Asynchronous reset while the request is held.
    begin
      sb_t e;
      wait_idle();
      ifc.miss_i       = 1'b1;
      ifc.miss_set_i   = 6'd20;
      ifc.valid_ways_i = 4'hF;
      e.set = 6'd20;
      e.way = 2'd0;
      sb.push_back(e);
      @(negedge clk);
      ifc.miss_i = 1'b0;
      @(negedge clk);
      check("arst_pre_req", 32'(ifc.refill_req_o), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("arst_req", 32'(ifc.refill_req_o), 32'd0);
      check("arst_busy", 32'(ifc.busy_o), 32'd0);
      check("arst_way", 32'(ifc.refill_way_o), 32'd0);
      check("arst_set", 32'(ifc.refill_set_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check("arst_stays_idle", 32'(ifc.refill_req_o), 32'd0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
